// File: rtl/raytracing_systimer_seq.sv
// -----------------------------------------------------------------------------
// raytracing_systimer_seq
//
// Sole master on the 16-bit Avalon-MM slave port of the system interval timer.
// It programs the 64-bit period and starts the timer in continuous mode. It can
// also stop the timer. Each timeout irq is serviced and turned into a one-cycle
// frame tick. On request it captures a 64-bit counter snapshot.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (op: 0=CONFIG 1=STOP 2=SNAP 3=nop)
//   cmd_op, cmd_period  command opcode and CONFIG period, latched on accept
//   tmr_*               timer slave port (no waitrequest, 1-cycle accesses,
//                       read data returned one cycle after the address)
//   tmr_irq             timer timeout irq (level, cleared by a status write)
//   running             timer started and not stopped since
//   tick, tick_count    serviced-timeout pulse and wrapping count
//   snap_value/valid    last counter snapshot and its one-cycle strobe
// -----------------------------------------------------------------------------
module raytracing_systimer_seq #(
  parameter logic [63:0] RESET_PERIOD = 64'd50_000_000,
  parameter bit          AUTO_START   = 1'b1,
  parameter int          TICK_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [63:0]       cmd_period,
  output logic              cmd_ready,
  output logic [3:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [63:0]       snap_value,
  output logic              snap_valid
);

  typedef enum logic [3:0] {
    IDLE, CFG_WR, CFG_CTRL, STOP_WR, IRQ_CLR, IRQ_HOLD, SNAP_WR, SNAP_RD, SNAP_CAP
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        idx_reg, idx_next;
  logic [63:0]       period_reg, period_next;
  logic              auto_owed_reg, auto_owed_next;
  logic              running_reg, running_next;
  logic              tick_reg, tick_next;
  logic [TICK_W-1:0] tick_count_reg, tick_count_next;
  logic [15:0]       hw_reg [3];
  logic [63:0]       snap_value_reg;
  logic [63:0]       snap_word;
  logic [15:0]       period_hw [4];

  // Period split into the four halfwords written to period registers 2..5.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_period_hw
      assign period_hw[gi] = period_reg[16*gi +: 16];
    end
  endgenerate

  // hw3 is still on the read bus during SNAP_CAP, so the fresh snapshot is
  // presented combinationally in that cycle and kept in snap_value_reg after.
  assign snap_word  = {tmr_readdata, hw_reg[2], hw_reg[1], hw_reg[0]};
  assign snap_valid = (state_reg == SNAP_CAP);
  assign snap_value = snap_valid ? snap_word : snap_value_reg;
  assign running    = running_reg;
  assign tick       = tick_reg;
  assign tick_count = tick_count_reg;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    period_next     = period_reg;
    auto_owed_next  = auto_owed_reg;
    running_next    = running_reg;
    tick_next       = 1'b0;
    tick_count_next = tick_count_reg;
    cmd_ready       = 1'b0;
    tmr_address     = 4'd0;
    tmr_chipselect  = 1'b0;
    tmr_write_n     = 1'b1;
    tmr_writedata   = 16'h0000;

    case (state_reg)
      IDLE: begin
        cmd_ready = !tmr_irq && !auto_owed_reg;
        if (tmr_irq) begin
          state_next = IRQ_CLR;
        end else if (auto_owed_reg) begin
          state_next     = CFG_WR;
          idx_next       = 2'd0;
          period_next    = RESET_PERIOD;
          auto_owed_next = 1'b0;
        end else if (cmd_valid) begin
          case (cmd_op)
            2'd0: begin
              state_next  = CFG_WR;
              idx_next    = 2'd0;
              period_next = cmd_period;
            end
            2'd1:    state_next = STOP_WR;
            2'd2:    state_next = SNAP_WR;
            default: state_next = IDLE;
          endcase
        end
      end

      CFG_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 4'd2 + {2'b00, idx_reg};
        tmr_writedata  = period_hw[idx_reg];
        idx_next       = idx_reg + 2'd1;
        if (idx_reg == 2'd3) state_next = CFG_CTRL;
      end

      CFG_CTRL: begin
        // START | CONT | ITO
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 4'd1;
        tmr_writedata  = 16'h0007;
        running_next   = 1'b1;
        state_next     = IDLE;
      end

      STOP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 4'd1;
        tmr_writedata  = 16'h0008;
        running_next   = 1'b0;
        state_next     = IDLE;
      end

      IRQ_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        state_next     = IRQ_HOLD;
      end

      // irq is still high here because the timer drops it only after the
      // clear lands, so it is deliberately not looked at in this state.
      IRQ_HOLD: begin
        tick_next       = 1'b1;
        tick_count_next = tick_count_reg + TICK_W'(1);
        state_next      = IDLE;
      end

      SNAP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 4'd6;
        idx_next       = 2'd0;
        state_next     = SNAP_RD;
      end

      SNAP_RD: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 4'd6 + {2'b00, idx_reg};
        idx_next       = idx_reg + 2'd1;
        if (idx_reg == 2'd3) state_next = SNAP_CAP;
      end

      SNAP_CAP: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      period_reg     <= 64'd0;
      auto_owed_reg  <= AUTO_START;
      running_reg    <= 1'b0;
      tick_reg       <= 1'b0;
      tick_count_reg <= '0;
      snap_value_reg <= 64'd0;
      for (int i = 0; i < 3; i++) hw_reg[i] <= 16'h0000;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      period_reg     <= period_next;
      auto_owed_reg  <= auto_owed_next;
      running_reg    <= running_next;
      tick_reg       <= tick_next;
      tick_count_reg <= tick_count_next;
      if (state_reg == SNAP_CAP) snap_value_reg <= snap_word;
      // Read data lags the address by one cycle: SNAP_RD(i) sees halfword i-1.
      for (int i = 0; i < 3; i++) begin
        if (state_reg == SNAP_RD && idx_reg == 2'(i + 1)) hw_reg[i] <= tmr_readdata;
      end
    end
  end

endmodule

// File: tb/tb_raytracing_systimer_seq.sv
// -----------------------------------------------------------------------------
// tb_raytracing_systimer_seq
//
// Bench for raytracing_systimer_seq. Expected timer-bus accesses are queued as
// commands are issued. A negedge monitor pops and compares each access the DUT
// makes. A small timer model latches a counter on the snapshot write and
// returns registered read data.
// -----------------------------------------------------------------------------
module tb_raytracing_systimer_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [63:0] cmd_period = 64'd0;
  logic        cmd_ready;
  logic [3:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = 16'h0000;
  logic        tmr_irq = 1'b0;
  logic        running;
  logic        tick;
  logic [31:0] tick_count;
  logic [63:0] snap_value;
  logic        snap_valid;

  raytracing_systimer_seq #(
    .RESET_PERIOD(64'h0000_0001_2345_6789),
    .AUTO_START  (1'b1),
    .TICK_W      (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_period    (cmd_period),
    .cmd_ready     (cmd_ready),
    .tmr_address   (tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n   (tmr_write_n),
    .tmr_writedata (tmr_writedata),
    .tmr_readdata  (tmr_readdata),
    .tmr_irq       (tmr_irq),
    .running       (running),
    .tick          (tick),
    .tick_count    (tick_count),
    .snap_value    (snap_value),
    .snap_valid    (snap_valid)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          snap_pulses = 0;
  logic [20:0] exp_q [$];
  int          bus_cyc [$];
  logic [63:0] counter_model = 64'd0;
  logic [63:0] snap_latch = 64'd0;
  logic [20:0] bus_got;
  logic [20:0] bus_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_wr(input logic [3:0] addr, input logic [15:0] data);
    exp_q.push_back({1'b1, addr, data});
  endtask

  task automatic exp_rd(input logic [3:0] addr);
    exp_q.push_back({1'b0, addr, 16'h0000});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Timer model: snapshot latch on a write to address 6, registered reads.
  always @(posedge clk) begin
    if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0 && tmr_address == 4'd6)
      snap_latch <= counter_model;
    if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b1) begin
      case (tmr_address)
        4'd6:    tmr_readdata <= snap_latch[15:0];
        4'd7:    tmr_readdata <= snap_latch[31:16];
        4'd8:    tmr_readdata <= snap_latch[47:32];
        4'd9:    tmr_readdata <= snap_latch[63:48];
        default: tmr_readdata <= 16'h0000;
      endcase
    end
  end

  // Bus monitor: one line per access, checked against the expectation queue.
  always @(negedge clk) begin
    if (tmr_chipselect === 1'b1) begin
      bus_got = {~tmr_write_n, tmr_address, (tmr_write_n ? 16'h0000 : tmr_writedata)};
      bus_cyc.push_back(cyc);
      $display("[%0d] bus %s addr=%0d data=%h", cyc, tmr_write_n ? "rd" : "wr",
               tmr_address, tmr_write_n ? tmr_readdata : tmr_writedata);
      check("bus_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        bus_exp = exp_q.pop_front();
        check("bus_access", bus_got, bus_exp);
      end
    end
    if (snap_valid === 1'b1) snap_pulses++;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [63:0] per, output int acc);
    logic ok;
    ok  = 1'b0;
    acc = 0;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_period = per;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1'b1);
    $display("[%0d] cmd op=%0d period=%h accepted at %0d", cyc, op, per, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, clr, ctrl, pos, n, base;
    logic found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 4'd0, 16'h0});
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_tick", {tick, tick_count}, 33'd0);
    check("rst_snap", {snap_valid, snap_value}, 65'd0);

    // 1: automatic start with RESET_PERIOD
    exp_wr(4'd2, 16'h6789); exp_wr(4'd3, 16'h2345); exp_wr(4'd4, 16'h0001);
    exp_wr(4'd5, 16'h0000); exp_wr(4'd1, 16'h0007);
    bus_cyc.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    drain();
    @(negedge clk);
    check("t1_running", running, 1'b1);
    check("t1_ready", cmd_ready, 1'b1);
    check("t1_count", bus_cyc.size(), 5);
    if (bus_cyc.size() == 5) check("t1_consecutive", bus_cyc[4] - bus_cyc[0], 4);

    // 2: timeout service
    @(posedge clk); #1;
    tmr_irq = 1'b1;
    exp_wr(4'd0, 16'h0000);
    found = 1'b0; clr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n && tmr_address == 4'd0) begin
        found = 1'b1; clr = cyc; break;
      end
    end
    tmr_irq = 1'b0;
    check("t2_clr_seen", found, 1'b1);
    n = 0; pos = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tick) begin n++; pos = cyc - clr; end
    end
    check("t2_tick_pulses", n, 1);
    check("t2_tick_delay", pos, 2);
    check("t2_tick_count", tick_count, 1);

    // 3: snapshot
    counter_model = 64'h0000_00AB_CDEF_0123;
    exp_wr(4'd6, 16'h0000); exp_rd(4'd6); exp_rd(4'd7); exp_rd(4'd8); exp_rd(4'd9);
    base = snap_pulses;
    send_cmd(2'd2, 64'd0, acc);
    pos = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (snap_valid) begin
        pos = cyc - acc;
        check("t3_snap_value", snap_value, 64'h0000_00AB_CDEF_0123);
        break;
      end
    end
    check("t3_snap_latency", pos, 6);
    drain();
    repeat (2) @(negedge clk);
    check("t3_snap_pulses", snap_pulses - base, 1);
    check("t3_snap_held", snap_value, 64'h0000_00AB_CDEF_0123);

    // 4: irq during CONFIG is serviced only after the sequence completes
    exp_wr(4'd2, 16'h4444); exp_wr(4'd3, 16'h3333); exp_wr(4'd4, 16'h2222);
    exp_wr(4'd5, 16'h1111); exp_wr(4'd1, 16'h0007); exp_wr(4'd0, 16'h0000);
    send_cmd(2'd0, 64'h1111_2222_3333_4444, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n && tmr_address == 4'd3) begin
        tmr_irq = 1'b1; break;
      end
    end
    check("t4_irq_raised", tmr_irq, 1'b1);
    found = 1'b0; ctrl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n && tmr_address == 4'd1) begin
        found = 1'b1; ctrl = cyc; break;
      end
    end
    check("t4_ctrl_seen", found, 1'b1);
    @(negedge clk);
    check("t4_ready_pending", cmd_ready, 1'b0);
    check("t4_running", running, 1'b1);
    @(negedge clk);
    check("t4_irqclr_next", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 4'd0});
    tmr_irq = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("t4_tick_count", tick_count, 2);

    // 5: STOP, then CONFIG with period 10
    exp_wr(4'd1, 16'h0008);
    send_cmd(2'd1, 64'd0, acc);
    drain();
    @(negedge clk);
    check("t5_stopped", running, 1'b0);
    exp_wr(4'd2, 16'h000A); exp_wr(4'd3, 16'h0000); exp_wr(4'd4, 16'h0000);
    exp_wr(4'd5, 16'h0000); exp_wr(4'd1, 16'h0007);
    send_cmd(2'd0, 64'd10, acc);
    drain();
    @(negedge clk);
    check("t5_running", running, 1'b1);

    // 6: reset during SNAP_RD(2)
    counter_model = 64'hDEAD_BEEF_0000_1111;
    exp_wr(4'd6, 16'h0000); exp_rd(4'd6); exp_rd(4'd7); exp_rd(4'd8);
    base = snap_pulses;
    send_cmd(2'd2, 64'd0, acc);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tmr_chipselect && tmr_write_n && tmr_address == 4'd8) begin
        found = 1'b1; break;
      end
    end
    check("t6_rd2_seen", found, 1'b1);
    reset = 1'b1;
    exp_wr(4'd2, 16'h6789); exp_wr(4'd3, 16'h2345); exp_wr(4'd4, 16'h0001);
    exp_wr(4'd5, 16'h0000); exp_wr(4'd1, 16'h0007);
    @(negedge clk);
    check("t6_bus_idle", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {1'b0, 1'b1, 4'd0, 16'h0});
    check("t6_running", running, 1'b0);
    check("t6_tick_count", tick_count, 0);
    check("t6_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    drain();
    @(negedge clk);
    check("t6_restarted", running, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_no_snap", snap_pulses - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
